// File: rtl/ws2812_serializer.sv
// ws2812_serializer: shifts a 24*NUM_LEDS-bit GRB frame onto the WS2812 line, then holds the latch low.
// Define WS2812_SERIALIZER_REPEAT_EN for a level-triggered start with back-to-back refresh.
module ws2812_serializer #(
    parameter int NUM_LEDS = 5,
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int BIT_CYC  = 62,
    parameter int RST_CYC  = 2600
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [24*NUM_LEDS-1:0]  grb_seq,
    input  logic                    send,
    output logic                    busy,
    output logic                    done,
    output logic                    dout
);

    localparam int FRAME_W = 24 * NUM_LEDS;
    localparam int BW      = $clog2(FRAME_W + 1);
    localparam int MAX_CYC = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYC);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]        cyc_cnt_q, cyc_cnt_d;
    logic                 latch_end_q, latch_end_d;
    logic                 dout_q, dout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start;
    logic                 load;
    logic [CW-1:0]        hi_len;

`ifdef WS2812_SERIALIZER_REPEAT_EN
    assign start = send;
`else
    logic send_hist_q, send_hist_d;

    assign send_hist_d = send;
    assign start       = send & ~send_hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_hist_q <= 1'b0;
        end else begin
            send_hist_q <= send_hist_d;
        end
    end
`endif

    assign hi_len = shift_q[FRAME_W-1] ? T1H_C : T0H_C;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        latch_end_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                load = start;
            end
            SEND: begin
                if (cyc_cnt_q == BIT_LAST) begin
                    cyc_cnt_d = '0;
                    shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = LATCH;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cyc_cnt_q == RST_LAST) begin
                    cyc_cnt_d   = '0;
                    latch_end_d = 1'b1;
                    state_d     = IDLE;
`ifdef WS2812_SERIALIZER_REPEAT_EN
                    load        = send;
`endif
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d   = grb_seq;
            bit_cnt_d = '0;
            cyc_cnt_d = '0;
            state_d   = SEND;
        end

        // Outputs trail the state by one register so dout/busy/done stay glitch-free and aligned.
        dout_d = (state_q == SEND) && (cyc_cnt_q < hi_len);
        busy_d = (state_q != IDLE);
        done_d = latch_end_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
            latch_end_q <= 1'b0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            latch_end_q <= latch_end_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer: a negedge monitor measures each bit and the latch against a scoreboard
// filled when frames are requested.
module tb_ws2812_serializer;

    localparam int NUM_LEDS = 5;
    localparam int FW       = 24 * NUM_LEDS;
    localparam int T0H      = 20;
    localparam int T1H      = 40;
    localparam int BITC     = 62;
    localparam int RSTC     = 2600;
    localparam int FRAME_CYC = FW * BITC + RSTC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FW-1:0] grb_seq;
    logic          send;
    logic          busy;
    logic          done;
    logic          dout;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned cyc = 0;
    int          exp_hi[$];
    int unsigned exp_done[$];
    logic        exp_busy[$];

    logic prev_dout = 1'b0;
    logic have_bit  = 1'b0;
    int   hi = 0;
    int   lo = 0;
    int   done_cnt = 0;

    ws2812_serializer #(
        .NUM_LEDS (NUM_LEDS),
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .BIT_CYC  (BITC),
        .RST_CYC  (RSTC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .grb_seq (grb_seq),
        .send    (send),
        .busy    (busy),
        .done    (done),
        .dout    (dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tb_check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic finish_bit();
        int e;
        if (exp_hi.size() == 0) begin
            tb_check("sb_bit_unexpected", 1, 0);
        end else begin
            e = exp_hi.pop_front();
            tb_check("bit_high", hi, e);
        end
        tb_check("bit_period", hi + lo, BITC);
    endtask

    task automatic finish_frame();
        int          e;
        int unsigned ed;
        logic        eb;
        if (have_bit) begin
            if (exp_hi.size() == 0) begin
                tb_check("sb_bit_unexpected", 1, 0);
            end else begin
                e = exp_hi.pop_front();
                tb_check("last_bit_high", hi, e);
            end
            tb_check("last_bit_plus_latch", hi + lo, BITC + RSTC);
        end else begin
            tb_check("done_without_bits", 0, 1);
        end
        have_bit = 1'b0;
        if (exp_done.size() == 0) begin
            tb_check("done_unexpected", 1, 0);
        end else begin
            ed = exp_done.pop_front();
            eb = exp_busy.pop_front();
            tb_check("done_cycle", cyc, ed);
            tb_check("done_busy", busy, eb);
        end
        done_cnt++;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            have_bit  = 1'b0;
            prev_dout = 1'b0;
        end else begin
            if (done) finish_frame();
            if (dout && !prev_dout) begin
                if (have_bit) finish_bit();
                have_bit = 1'b1;
                hi = 1;
                lo = 0;
            end else if (dout) begin
                hi++;
            end else if (have_bit) begin
                lo++;
            end
            prev_dout = dout;
        end
    end

    task automatic push_frame(input logic [FW-1:0] f, input int unsigned done_at, input logic busy_at);
        for (int i = FW - 1; i >= 0; i--) exp_hi.push_back(f[i] ? T1H : T0H);
        exp_done.push_back(done_at);
        exp_busy.push_back(busy_at);
    endtask

    // Start is sampled on the posedge after send rises; done shows FRAME_CYC+1 edges later.
    task automatic drive_pulse(input logic [FW-1:0] f);
        @(negedge clk);
        grb_seq = f;
        push_frame(f, cyc + 1 + FRAME_CYC + 1, 1'b0);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int guard = 0;
        while (done_cnt < n && guard < FRAME_CYC + 2000) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt < n) tb_check("timeout_done", done_cnt, n);
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW; i += 24) f[i +: 24] = 24'($urandom);
        return f;
    endfunction

    initial begin
        logic [FW-1:0] f;
        rst_n   = 1'b0;
        send    = 1'b1;
        grb_seq = rand_frame();
        repeat (4) begin
            @(negedge clk);
            tb_check("rst_dout", dout, 0);
            tb_check("rst_busy", busy, 0);
            tb_check("rst_done", done, 0);
        end
        send = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        tb_check("idle_busy", busy, 0);
        tb_check("idle_dout", dout, 0);
        tb_check("idle_done_cnt", done_cnt, 0);

        f = {24'hFFFF00, 96'h0};
        drive_pulse(f);
        wait_done(1);

        f = rand_frame();
        drive_pulse(f);
        repeat (10 * BITC + 5) @(negedge clk);
        grb_seq = '1;
        wait_done(2);

        f = rand_frame();
        drive_pulse(f);
        repeat (60 * BITC + 7) @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_done(3);
        repeat (200) @(negedge clk);
        tb_check("lockout_busy", busy, 0);
        tb_check("lockout_done_cnt", done_cnt, 3);

        f = rand_frame();
        drive_pulse(f);
        repeat (50 * BITC + 3) @(negedge clk);
        tb_check("pre_reset_dout", dout, 1);
        #2 rst_n = 1'b0;
        #1;
        tb_check("async_rst_dout", dout, 0);
        tb_check("async_rst_busy", busy, 0);
        exp_hi.delete();
        exp_done.delete();
        exp_busy.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        tb_check("post_rst_busy", busy, 0);
        f = rand_frame();
        drive_pulse(f);
        wait_done(4);

`ifdef WS2812_SERIALIZER_REPEAT_EN
        @(negedge clk);
        f = 120'h00FF00;
        grb_seq = f;
        push_frame(f, cyc + 1 + FRAME_CYC + 1, 1'b1);
        push_frame(f, cyc + 1 + 2 * FRAME_CYC + 1, 1'b1);
        push_frame(f, cyc + 1 + 3 * FRAME_CYC + 1, 1'b0);
        send = 1'b1;
        wait_done(5);
        wait_done(6);
        repeat (3) @(negedge clk);
        send = 1'b0;
        wait_done(7);
        repeat (50) @(negedge clk);
        tb_check("repeat_end_busy", busy, 0);
`endif

        tb_check("sb_bits_left", exp_hi.size(), 0);
        tb_check("sb_done_left", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
